// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// The JUMP state exists only when MC_JUMP_EN is defined.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef MC_JUMP_EN
    JUMP    = 4'd11,
`endif
    ERROR   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam int ALU_CODE_W = 3;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

  // States that hold mem_req high and wait for mem_ack.
  function automatic logic is_mem_state(state_e s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational R-type funct decoder: yields the ALU operation code and
// whether the funct is one the datapath supports.
module mc_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0]            funct,
  output logic [ALU_CODE_W-1:0] alu_ctrl,
  output logic                  legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct)
      F_ADD:   alu_ctrl = ALU_ADD;
      F_SUB:   alu_ctrl = ALU_SUB;
      F_AND:   alu_ctrl = ALU_AND;
      F_OR:    alu_ctrl = ALU_OR;
      F_SLT:   alu_ctrl = ALU_SLT;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with memory wait/timeout handling and a sticky
// error state. Define MC_JUMP_EN to support the j instruction.
module mc_control_unit
  import mips_mc_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 err,
  output logic [3:0]           state_o
);

  localparam logic [TO_CNT_W-1:0] TIMEOUT_CNT = TO_CNT_W'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  logic [TO_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic [TO_CNT_W-1:0]   wait_inc;
  logic                  timed_out;
  state_e                stall_state;
  logic [ALU_CODE_W-1:0] dec_alu, alu_code;
  logic                  dec_legal;

  mc_alu_decoder u_alu_dec (
    .funct    (funct),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  // Memory handshake: mem_req is held for the whole stay in a memory state;
  // the access completes on the cycle mem_ack=1 is seen while mem_req=1, and
  // mem_ack in any other state has no effect. An ack on the cycle the wait
  // count would hit MEM_TIMEOUT still completes the access.
  assign wait_inc    = wait_cnt_q + 1'b1;
  assign timed_out   = (MEM_TIMEOUT != 0) && (wait_inc == TIMEOUT_CNT);
  assign stall_state = timed_out ? ERROR : state_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (is_mem_state(state_q) && !mem_ack) wait_cnt_d = wait_inc;
    case (state_q)
      FETCH:   state_d = mem_ack ? DECODE : stall_state;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_d = JUMP;
`endif
          default:      state_d = ERROR;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = mem_ack ? MEMWB : stall_state;
      MEMWR:   state_d = mem_ack ? FETCH : stall_state;
      EXECUTE: state_d = dec_legal ? ALUWB : ERROR;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB: state_d = FETCH;
`ifdef MC_JUMP_EN
      JUMP:    state_d = FETCH;
`endif
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
    err_d = err_q | (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Outputs follow the state; only IRWrite/PCEn look at mem_ack or zero.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    PCEn     = 1'b0;
    alu_code = '0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          ALUSrcB  = 2'b01;
          alu_code = ALU_ADD;
          IRWrite  = mem_ack;
          PCEn     = mem_ack;
        end
        DECODE: begin
          ALUSrcB  = 2'b10;
          alu_code = ALU_ADD;
        end
        MEMADR, ADDIEX: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          alu_code = ALU_ADD;
        end
        MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA  = 1'b1;
          alu_code = dec_alu;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA  = 1'b1;
          alu_code = ALU_SUB;
          PCSrc    = 2'b01;
          PCEn     = zero;
        end
        ADDIWB:  RegWrite = 1'b1;
`ifdef MC_JUMP_EN
        JUMP: begin
          PCSrc = 2'b10;
          PCEn  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign ALUControl = ALUCTRL_W'(alu_code);
  assign err        = err_q;
  assign state_o    = reset ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: randomized instruction streams
// with memory waits, checked cycle by cycle against a reference model.
module tb_mc_control_unit;
  import mips_mc_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct packed {
    logic mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [2:0] ALUControl;
    logic       err;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ack;
  logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       PCEn;
  logic [2:0] ALUControl;
  logic       err;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int last_irw = 0;
  int last_pcen = 0;

  logic [3:0] exp_q[$];
  logic       ack_q[$];

  always #5 clk = ~clk;

  mc_control_unit #(.ALUCTRL_W(3), .MEM_TIMEOUT(TB_TIMEOUT), .TO_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl),
    .err(err), .state_o(state_o)
  );

  function automatic outs_t observe();
    return outs_t'({mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, err});
  endfunction

  // Instruction-set table for R-type functs.
  function automatic logic alu_ref(input logic [5:0] fn, output logic [2:0] code);
    code = 3'b000;
    case (fn)
      6'b100000: begin code = 3'b010; return 1'b1; end
      6'b100010: begin code = 3'b110; return 1'b1; end
      6'b100100: begin code = 3'b000; return 1'b1; end
      6'b100101: begin code = 3'b001; return 1'b1; end
      6'b101010: begin code = 3'b111; return 1'b1; end
      default:   return 1'b0;
    endcase
  endfunction

  function automatic void model_outs(input state_e s, input logic ack, input logic z,
                                     input logic [5:0] fn, output outs_t o, output outs_t care);
    logic [2:0] code;
    logic       ok;
    o    = '0;
    care = '1;
    case (s)
      FETCH:   begin o.mem_req = 1; o.ALUSrcB = 2'b01; o.ALUControl = 3'b010;
                     o.IRWrite = ack; o.PCEn = ack; end
      DECODE:  begin o.ALUSrcB = 2'b10; o.ALUControl = 3'b010; end
      MEMADR:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.ALUControl = 3'b010; end
      MEMRD:   begin o.mem_req = 1; o.IorD = 1; end
      MEMWB:   begin o.RegWrite = 1; o.MemtoReg = 1; end
      MEMWR:   begin o.mem_req = 1; o.IorD = 1; o.MemWrite = 1; end
      EXECUTE: begin
        o.ALUSrcA = 1;
        ok = alu_ref(fn, code);
        o.ALUControl = code;
        if (!ok) care.ALUControl = 3'b000;
      end
      ALUWB:   begin o.RegWrite = 1; o.RegDst = 1; end
      BRANCH:  begin o.ALUSrcA = 1; o.ALUControl = 3'b110; o.PCSrc = 2'b01; o.PCEn = z; end
      ADDIEX:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.ALUControl = 3'b010; end
      ADDIWB:  o.RegWrite = 1;
`ifdef MC_JUMP_EN
      JUMP:    begin o.PCSrc = 2'b10; o.PCEn = 1; end
`endif
      ERROR:   o.err = 1;
      default: ;
    endcase
  endfunction

  function automatic void push(state_e s, logic ack);
    exp_q.push_back(4'(s));
    ack_q.push_back(ack);
  endfunction

  // w idle cycles before the ack; reaching the timeout ends in ERROR.
  function automatic void push_wait(state_e s, int w);
    if (w >= TB_TIMEOUT) begin
      for (int i = 0; i < TB_TIMEOUT; i++) push(s, 1'b0);
      push(ERROR, 1'($urandom));
    end else begin
      for (int i = 0; i < w; i++) push(s, 1'b0);
      push(s, 1'b1);
    end
  endfunction

  function automatic void build(logic [5:0] o, logic [5:0] fn, int fw, int mw);
    logic [2:0] code;
    exp_q.delete();
    ack_q.delete();
    push_wait(FETCH, fw);
    if (exp_q[$] == 4'(ERROR)) return;
    push(DECODE, 1'($urandom));
    if (o == LW || o == SW) begin
      push(MEMADR, 1'($urandom));
      push_wait((o == LW) ? MEMRD : MEMWR, mw);
      if (o == LW && exp_q[$] != 4'(ERROR)) push(MEMWB, 1'($urandom));
    end else if (o == RT) begin
      push(EXECUTE, 1'($urandom));
      push(alu_ref(fn, code) ? ALUWB : ERROR, 1'($urandom));
    end else if (o == BEQ) begin
      push(BRANCH, 1'($urandom));
    end else if (o == ADDI) begin
      push(ADDIEX, 1'($urandom));
      push(ADDIWB, 1'($urandom));
`ifdef MC_JUMP_EN
    end else if (o == JMP) begin
      push(JUMP, 1'($urandom));
`endif
    end else begin
      push(ERROR, 1'($urandom));
    end
  endfunction

  // Phase on entry/exit: just after a rising edge, DUT sitting in FETCH.
  task automatic do_reset(string tag);
    reset = 1'b1;
    mem_ack = 1'($urandom);
    #1;
    n_checks++;
    if ({observe(), state_o} !== 21'd0)
      $display("FAIL %s_reset_outs: got %h expected 0", tag, {observe(), state_o});
    @(posedge clk); #1;
    n_checks++;
    if ({observe(), state_o} !== 21'd0)
      $display("FAIL %s_reset_hold: got %h expected 0", tag, {observe(), state_o});
    reset = 1'b0;
  endtask

  task automatic run_seq(string tag, logic [5:0] o, logic [5:0] fn, logic z, int fw, int mw);
    outs_t e, care, a;
    bit    errored;
    build(o, fn, fw, mw);
    errored = (exp_q[$] == 4'(ERROR));
    if (errored) begin
      push(ERROR, 1'($urandom));
      push(ERROR, 1'($urandom));
    end
    op = o; funct = fn; zero = z;
    last_irw = 0; last_pcen = 0;
    foreach (exp_q[i]) begin
      mem_ack = ack_q[i];
      if (exp_q[i] == 4'(ERROR)) begin op = 6'($urandom); zero = 1'($urandom); end
      #1;
      a = observe();
      model_outs(state_e'(exp_q[i]), ack_q[i], zero, funct, e, care);
      if (a.IRWrite === 1'b1) last_irw++;
      if (a.PCEn === 1'b1) last_pcen++;
      n_checks++;
      if (state_o !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_state[%0d]: got %0d expected %0d", tag, i, state_o, exp_q[i]);
      end
      n_checks++;
      if (((a ^ e) & care) !== '0) begin
        n_fail++;
        $display("FAIL %s_outs[%0d]: got %h expected %h", tag, i, a, e);
      end
      @(posedge clk); #1;
    end
    if (errored) begin
      do_reset(tag);
    end else begin
      n_checks++;
      if (state_o !== 4'(FETCH)) begin
        n_fail++;
        $display("FAIL %s_return: got %0d expected %0d", tag, state_o, 4'(FETCH));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op = LW; funct = 6'd0; zero = 1'b0; mem_ack = 1'b1;
    #2;
    n_checks++;
    if ({observe(), state_o} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h expected 0", {observe(), state_o});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw();
    run_seq("lw0", LW, 6'($urandom), 1'($urandom), 0, 0);
    run_seq("sw0", SW, 6'($urandom), 1'($urandom), 0, 0);
    run_seq("rtype0", RT, 6'b100010, 1'b0, 0, 0);
    run_seq("addi0", ADDI, 6'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_fetch_wait();
    run_seq("fetch_wait", ADDI, 6'd0, 1'b0, 3, 0);
    n_checks++;
    if (last_irw !== 1) begin
      n_fail++;
      $display("FAIL fetch_wait_irwrite: got %0d pulses expected 1", last_irw);
    end
    n_checks++;
    if (last_pcen !== 1) begin
      n_fail++;
      $display("FAIL fetch_wait_pcen: got %0d pulses expected 1", last_pcen);
    end
  endtask

  task automatic test_branch();
    run_seq("beq_taken", BEQ, 6'($urandom), 1'b1, 0, 0);
    run_seq("beq_not", BEQ, 6'($urandom), 1'b0, 1, 0);
  endtask

  task automatic test_timeout();
    run_seq("rd_timeout", LW, 6'd0, 1'b0, 0, 4);
    run_seq("rd_ack_last", LW, 6'd0, 1'b0, 0, 3);
    run_seq("wr_timeout", SW, 6'd0, 1'b0, 2, 5);
    run_seq("fetch_timeout", ADDI, 6'd0, 1'b0, 4, 0);
  endtask

  task automatic test_illegal();
    run_seq("op_illegal", 6'b111111, 6'b100000, 1'b0, 0, 0);
    run_seq("funct_illegal", RT, 6'b000000, 1'b0, 0, 0);
    run_seq("jump", JMP, 6'($urandom), 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    op = SW; funct = 6'd0; zero = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'($urandom);
    @(posedge clk); #1; mem_ack = 1'($urandom);
    @(posedge clk); #1; mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({state_o, MemWrite, mem_req} !== {4'(MEMWR), 2'b11}) begin
      n_fail++;
      $display("FAIL midwr_pre: got %h expected %h", {state_o, MemWrite, mem_req}, {4'(MEMWR), 2'b11});
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({observe(), state_o} !== 21'd0) begin
      n_fail++;
      $display("FAIL midwr_drop: got %h expected 0", {observe(), state_o});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({state_o, mem_req, MemWrite} !== {4'(FETCH), 2'b10}) begin
      n_fail++;
      $display("FAIL midwr_resume: got %h expected %h", {state_o, mem_req, MemWrite}, {4'(FETCH), 2'b10});
    end
    run_seq("after_reset", LW, 6'd0, 1'b0, 3, 3);
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{LW, SW, RT, BEQ, ADDI, JMP};
    logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] o, fn;
    int fw, mw;
    for (int k = 0; k < 60; k++) begin
      o  = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      fw = ($urandom_range(0, 19) == 0) ? TB_TIMEOUT : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? TB_TIMEOUT : $urandom_range(0, 3);
      run_seq("rand", o, fn, 1'($urandom), fw, mw);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_fetch_wait();
    test_branch();
    test_timeout();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3, the ALUControl width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of wait cycles per memory access; 0 disables the timeout.
REQ-003 SHALL have parameter TO_CNT_W, default 8, the wait-counter width; MEM_TIMEOUT < 2**TO_CNT_W.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 op  in  6  Instr[31:26], valid while IR is held.
REQ-008 funct  in  6  Instr[5:0].
REQ-009 zero  in  1  ALU zero flag.
REQ-010 mem_ack  in  1  memory completes the current access this cycle.
REQ-011 mem_req  out  1  memory access requested.
REQ-012 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  out  1 each  datapath controls.
REQ-013 ALUSrcB  out  2  00 RD2, 01 const 4, 10 SignImm.
REQ-014 PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
REQ-015 PCEn  out  1  PC write enable.
REQ-016 ALUControl  out  ALUCTRL_W  ALU operation.
REQ-017 err  out  1  sticky fault flag.
REQ-018 state_o  out  4  current state encoding, for debug.

Function
REQ-019 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP and ERROR.
REQ-020 FETCH SHALL assert mem_req with IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add and PCSrc=00; it stays in FETCH until mem_ack=1.
REQ-021 IRWrite and PCEn SHALL pulse only in the FETCH cycle where mem_ack=1; that edge moves the FSM to DECODE.
REQ-022 DECODE SHALL route the FSM by op: 100011 or 101011 to MEMADR, 000000 to EXECUTE, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP; any other op goes to ERROR.
REQ-023 DECODE SHALL drive ALUSrcA=0, ALUSrcB=10, ALUControl=add (branch target).
REQ-024 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, add, then go to MEMRD for lw or MEMWR for sw.
REQ-025 MEMRD SHALL assert mem_req with IorD=1 and wait for mem_ack, then go to MEMWB.
REQ-026 MEMWR SHALL assert mem_req, IorD=1 and MemWrite=1; MemWrite stays high until mem_ack, then the FSM returns to FETCH.
REQ-027 MEMWB SHALL assert RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-028 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00 and funct-decoded ALUControl: 100000 add 010, 100010 sub 110, 100100 and 000, 100101 or 001, 101010 slt 111.
REQ-029 An unknown funct in EXECUTE SHALL move the FSM to ERROR with RegWrite never asserted; otherwise the FSM goes to ALUWB.
REQ-030 ALUWB SHALL assert RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-031 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01 and PCEn=zero, then go to FETCH.
REQ-032 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, add, then go to ADDIWB.
REQ-033 ADDIWB SHALL assert RegWrite=1, RegDst=0, then go to FETCH.
REQ-034 Latency in cycles with zero-wait memory SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-035 A wait counter SHALL clear on entry to any mem_req state and increment each cycle without mem_ack.
REQ-036 When MEM_TIMEOUT != 0 and the wait count reaches MEM_TIMEOUT, the FSM SHALL go to ERROR.
REQ-037 If mem_ack arrives on the same cycle the count reaches MEM_TIMEOUT, the ack SHALL win.
REQ-038 ERROR SHALL set err=1, drive all other outputs to 0 and hold until reset.
REQ-039 mem_ack outside a mem_req state SHALL be ignored.

Reset
REQ-040 Reset SHALL force state FETCH, wait count 0 and err=0.
REQ-041 While reset is high, every output SHALL be 0, including mem_req.
REQ-042 Reset asserted mid-access SHALL abort the access; fetch restarts on the first rising edge after release.

Configuration
REQ-043 With MC_JUMP_EN defined, op 000010 SHALL go to JUMP, which drives PCSrc=10 and PCEn=1, then goes to FETCH.
REQ-044 Without MC_JUMP_EN, the JUMP state SHALL be absent and op 000010 SHALL be illegal (goes to ERROR).

Structure
REQ-045 Package mips_mc_pkg SHALL hold the state enum, opcode and funct constants, and the ALUControl codes.
REQ-046 Sub-module mc_alu_decoder SHALL be combinational, mapping funct to {ALUControl, legal}.

Verification
REQ-047 lw with mem_ack always 1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH over 5 cycles; RegWrite=1 with MemtoReg=1 in cycle 5.
REQ-048 Fetch with mem_ack delayed 3 cycles: FETCH held for 4 cycles; IRWrite and PCEn each high exactly once.
REQ-049 beq with zero=1, then again with zero=0: PCEn=1 with PCSrc=01 for zero=1; PCEn=0 for zero=0.
REQ-050 MEM_TIMEOUT=4 and mem_ack held low in MEMRD: ERROR after 4 wait cycles, err=1, outputs 0; ack on the 4th cycle instead goes to MEMWB.
REQ-051 op=111111, and R-type with funct=000000: both go to ERROR with no RegWrite; op=000010 goes to JUMP only when MC_JUMP_EN is defined.
REQ-052 Reset pulse during MEMWR: MemWrite and mem_req drop immediately; FETCH resumes after release.
